ax309_mem_ctl: RTL and testbench
================================

# ax309_mem_ctl

Wishbone slave controller that drives the on-board 8K×16 block-RAM port: it translates single classic Wishbone cycles from the CPU bus into the RAM's registered-address/registered-write-enable access sequence and returns an acknowledge. It sits between the CPU11 bus fabric and the RAM instance on the AX309 board. It is the initiator of every RAM port transaction and owns all of that port's timing.

## Interface
Parameters:
- WAIT, 0, extra wait states inserted between RAM address latch and data capture (0..7)

Ports:
- clk  in  1  system clock, shared with the RAM port clock
- rst_n  in  1  asynchronous active-low reset
- wb_adr_i  in  14  byte address; bit 0 ignored, [13:1] select the word
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data, valid while wb_ack_o=1
- wb_cyc_i  in  1  bus cycle
- wb_stb_i  in  1  strobe
- wb_we_i  in  1  1=write
- wb_sel_i  in  2  byte lane select ([0]=low byte)
- wb_ack_o  out  1  acknowledge, one-cycle pulse
- mem_addr  out  13  RAM word address
- mem_din  out  16  RAM write data
- mem_we  out  1  RAM write enable
- mem_be  out  2  RAM byte enables
- mem_dout  in  16  RAM read data (combinational from RAM's latched address)

## Operation
- RAM port behaviour being driven: at edge N the RAM latches address and (we & be); at edge N+1 it writes mem_din into latched address; read data valid combinationally after edge N.
- All outputs registered. Reset values: wb_ack_o=0, wb_dat_o=0, mem_addr=0, mem_din=0, mem_we=0, mem_be=0, state=IDLE, wait counter=0.
- States: IDLE, ACCESS, WAIT, COMPLETE, ACKED.
- IDLE: request = wb_cyc_i & wb_stb_i. On request: mem_addr<=wb_adr_i[13:1], mem_be<=wb_sel_i, mem_we<=wb_we_i, mem_din<=wb_dat_i; -> ACCESS.
- ACCESS: RAM latches address/enable on this edge; mem_we<=0; load counter with WAIT; -> WAIT if WAIT>0 else COMPLETE.
- WAIT: decrement counter; -> COMPLETE when counter reaches 1.
- COMPLETE: pending write commits (mem_din still held). If read: wb_dat_o<=mem_dout. wb_ack_o<=wb_cyc_i; -> ACKED.
- ACKED: wb_ack_o<=0; -> IDLE. Requests are not sampled in ACKED.
- wb_dat_o holds last read value across writes and idle.
- mem_addr, mem_be, mem_din held unchanged from IDLE capture until next capture.
- wb_sel_i=0 write: sequence runs, no byte modified, ack returned. wb_sel_i=0 read: full word returned.
- wb_cyc_i dropped mid-transfer: RAM access runs to completion (write still commits); ack suppressed if wb_cyc_i=0 in COMPLETE; FSM still passes through ACKED.
- Reset asserted mid-transfer: outputs clear immediately; content of the in-flight word is undefined if reset falls between ACCESS and COMPLETE edges; all other words untouched.

## Timing
- Edge E0: request captured (IDLE->ACCESS). E1: RAM latches address (ACCESS). E2+WAIT: data captured, ack rises. E3+WAIT: ack falls.
- Request-to-ack latency: 3+WAIT clocks from first edge sampling the request; ack high exactly one cycle.
- mem_we high for exactly one cycle per write (E0..E1).
- Back-to-back: next request sampled earliest at E4+WAIT; throughput one transfer per 4+WAIT clocks.
- Master must hold wb_adr_i/wb_dat_i only until E0; later changes have no effect.

## Test plan
- Reset: assert rst_n=0 mid-idle with random bus inputs -> all outputs 0 asynchronously, no mem_we pulse after release.
- Word write/read, WAIT=0: write 0xA55A to byte addr 0x0010, sel=2'b11, then read 0x0010 -> mem_we pulse of one cycle with mem_addr=0x008, ack 3 clocks after request, read returns 0xA55A.
- Byte lanes: preload 0x1234 at 0x0020; write 0xFFAA sel=2'b01 -> read 0x12AA; write 0xBBFF sel=2'b10 -> read 0xBBAA; sel=2'b00 write -> unchanged, ack still returned.
- WAIT=3: read 0x3FFE (word 0x1FFF, top boundary) -> ack exactly 6 clocks after request, correct data; back-to-back requests spaced 7 clocks.
- Abort: drop wb_cyc_i one cycle after write request of 0x5555 to 0x0040 -> no ack, FSM returns to IDLE in 4 clocks, read of 0x0040 returns 0x5555.
- Held strobe: keep cyc/stb high through ack -> exactly one ack pulse per 4 clocks, each followed by a fresh access, no double write.

Source files
------------

// File: rtl/ax309_mem_ctl.sv
// ax309_mem_ctl: Wishbone classic slave fronting the 8K x 16 block-RAM port.
// Converts one Wishbone cycle into the RAM's registered address / write-enable
// sequence and returns a single-cycle acknowledge.
module ax309_mem_ctl #(
  parameter int unsigned WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic [12:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  input  logic [15:0] mem_dout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_COMPLETE,
    S_ACKED
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  wait_cnt;
  logic        rd_op;
  logic        request;
  logic        unused_adr_bit;

  // Byte address bit 0 carries no information for a 16-bit word RAM.
  assign unused_adr_bit = wb_adr_i[0];
  assign request        = wb_cyc_i & wb_stb_i;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; WAIT state count equals the WAIT parameter.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (request) state_next = S_ACCESS;
      S_ACCESS:   state_next = (WAIT != 0) ? S_WAIT : S_COMPLETE;
      S_WAIT:     if (wait_cnt == 3'd1) state_next = S_COMPLETE;
      S_COMPLETE: state_next = S_ACKED;
      S_ACKED:    state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Registered datapath: request capture, RAM port drive, read capture, ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      mem_be   <= '0;
      wait_cnt <= '0;
      rd_op    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (request) begin
            mem_addr <= wb_adr_i[13:1];
            mem_be   <= wb_sel_i;
            mem_we   <= wb_we_i;
            mem_din  <= wb_dat_i;
            rd_op    <= ~wb_we_i;
          end
        end
        S_ACCESS: begin
          // RAM latches address and enables on this edge; the write itself
          // lands one edge later while mem_din is still held.
          mem_we   <= 1'b0;
          wait_cnt <= 3'(WAIT);
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 3'd1;
        end
        S_COMPLETE: begin
          if (rd_op) wb_dat_o <= mem_dout;
          // An aborted cycle still completes at the RAM but is not acked.
          wb_ack_o <= wb_cyc_i;
        end
        S_ACKED: begin
          wb_ack_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ax309_mem_ctl.sv
// Bench for ax309_mem_ctl: two instances (WAIT=0 and WAIT=3), each with its own
// behavioural RAM port model, checked against a word-array reference memory.
module tb_ax309_mem_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] wb_adr;
  logic [15:0] wb_dat;
  logic        wb_we;
  logic [1:0]  wb_sel;
  logic [1:0]  cyc;
  logic [1:0]  stb;

  logic [15:0] dat_o    [2];
  logic [1:0]  ack;
  logic [12:0] mem_addr [2];
  logic [15:0] mem_din  [2];
  logic [1:0]  mem_we;
  logic [1:0]  mem_be   [2];
  logic [15:0] mem_dout [2];

  logic [15:0] ref_mem  [2][8192];
  logic [15:0] last_rd  [2];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  // DUT instances plus a RAM port model each: latch at edge N, write at N+1.
  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic [15:0] ram [8192];
    logic [12:0] la;
    logic        lwe = 1'b0;
    logic [1:0]  lbe;

    ax309_mem_ctl #(.WAIT(g * 3)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .wb_adr_i (wb_adr),
      .wb_dat_i (wb_dat),
      .wb_dat_o (dat_o[g]),
      .wb_cyc_i (cyc[g]),
      .wb_stb_i (stb[g]),
      .wb_we_i  (wb_we),
      .wb_sel_i (wb_sel),
      .wb_ack_o (ack[g]),
      .mem_addr (mem_addr[g]),
      .mem_din  (mem_din[g]),
      .mem_we   (mem_we[g]),
      .mem_be   (mem_be[g]),
      .mem_dout (mem_dout[g])
    );

    always @(posedge clk) begin
      if (lwe) begin
        if (lbe[0]) ram[la][7:0]  <= mem_din[g][7:0];
        if (lbe[1]) ram[la][15:8] <= mem_din[g][15:8];
      end
      la  <= mem_addr[g];
      lwe <= mem_we[g];
      lbe <= mem_be[g];
    end
    assign mem_dout[g] = ram[la];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic ref_write(input int i, input logic [13:0] adr, input logic [15:0] d,
                           input logic [1:0] s);
    if (s[0]) ref_mem[i][adr[13:1]][7:0]  = d[7:0];
    if (s[1]) ref_mem[i][adr[13:1]][15:8] = d[15:8];
  endtask

  // One Wishbone transfer on instance i with latency/pulse/data checks.
  task automatic xfer(input int i, input logic we, input logic [13:0] adr,
                      input logic [15:0] dat, input logic [1:0] sel);
    int          lat;
    int          wec;
    int          wt;
    logic        got;
    logic [15:0] rd;
    wt  = (i == 0) ? 0 : 3;
    lat = 0;
    wec = 0;
    got = 1'b0;
    rd  = '0;
    @(negedge clk);
    wb_adr = adr; wb_dat = dat; wb_we = we; wb_sel = sel;
    cyc[i] = 1'b1; stb[i] = 1'b1;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clk);
      if (mem_we[i]) wec++;
      if (n == 1) begin
        chk("mem_addr", 32'(mem_addr[i]), 32'(adr[13:1]));
        chk("mem_be", 32'(mem_be[i]), 32'(sel));
        if (we) chk("mem_din", 32'(mem_din[i]), 32'(dat));
        wb_adr = 14'($urandom);
        wb_dat = 16'($urandom);
      end
      if (ack[i]) begin
        got = 1'b1;
        lat = n;
        rd  = dat_o[i];
        chk("addr_hold", 32'(mem_addr[i]), 32'(adr[13:1]));
      end
    end
    cyc[i] = 1'b0; stb[i] = 1'b0;
    chk("ack_latency", 32'(lat), 32'(3 + wt));
    chk("we_pulses", 32'(wec), we ? 32'd1 : 32'd0);
    @(negedge clk);
    chk("ack_low", 32'(ack[i]), 32'd0);
    if (we) begin
      ref_write(i, adr, dat, sel);
      chk("rdata_hold", 32'(dat_o[i]), 32'(last_rd[i]));
    end else begin
      chk("rdata", 32'(rd), 32'(ref_mem[i][adr[13:1]]));
      last_rd[i] = ref_mem[i][adr[13:1]];
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [13:0] pool [6];
    int          acks;
    int          wes;
    int          idx;

    rst_n = 1'b0; cyc = '0; stb = '0;
    wb_adr = '0; wb_dat = '0; wb_we = 1'b0; wb_sel = '0;
    last_rd[0] = '0; last_rd[1] = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ack", 32'(ack[i]), 32'd0);
      chk("rst_we", 32'(mem_we[i]), 32'd0);
      chk("rst_dat", 32'(dat_o[i]), 32'd0);
      chk("rst_addr", 32'(mem_addr[i]), 32'd0);
    end
    #20;
    @(negedge clk) rst_n = 1'b1;

    // Word write/read at byte 0x0010 (word 0x008), WAIT=0.
    xfer(0, 1'b1, 14'h0010, 16'hA55A, 2'b11);
    xfer(0, 1'b0, 14'h0010, 16'h0000, 2'b11);

    // Byte lanes at 0x0020.
    xfer(0, 1'b1, 14'h0020, 16'h1234, 2'b11);
    xfer(0, 1'b1, 14'h0020, 16'hFFAA, 2'b01);
    xfer(0, 1'b0, 14'h0020, 16'h0000, 2'b11);
    chk("lane_lo", 32'(last_rd[0]), 32'h12AA);
    xfer(0, 1'b1, 14'h0020, 16'hBBFF, 2'b10);
    xfer(0, 1'b0, 14'h0020, 16'h0000, 2'b11);
    chk("lane_hi", 32'(last_rd[0]), 32'hBBAA);
    xfer(0, 1'b1, 14'h0020, 16'h0000, 2'b00);
    xfer(0, 1'b0, 14'h0020, 16'h0000, 2'b00);
    chk("lane_none", 32'(last_rd[0]), 32'hBBAA);

    // Abort: write 0x5555 to 0x0040, drop cyc one cycle after request.
    @(negedge clk);
    wb_adr = 14'h0040; wb_dat = 16'h5555; wb_we = 1'b1; wb_sel = 2'b11;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(negedge clk);
    cyc[0] = 1'b0;
    acks = 0;
    for (int n = 2; n <= 8; n++) begin
      @(negedge clk);
      if (ack[0]) acks++;
    end
    stb[0] = 1'b0;
    chk("abort_no_ack", 32'(acks), 32'd0);
    ref_write(0, 14'h0040, 16'h5555, 2'b11);
    xfer(0, 1'b0, 14'h0040, 16'h0000, 2'b11);

    // Held strobe on WAIT=0: one ack and one write every 4 clocks.
    @(negedge clk);
    wb_adr = 14'h0050; wb_dat = 16'hC3C3; wb_we = 1'b1; wb_sel = 2'b11;
    cyc[0] = 1'b1; stb[0] = 1'b1;
    acks = 0; wes = 0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      chk("held_ack", 32'(ack[0]), 32'(((n - 1) % 4) == 2));
      chk("held_we", 32'(mem_we[0]), 32'(((n - 1) % 4) == 0));
      if (ack[0]) acks++;
      if (mem_we[0]) wes++;
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    chk("held_acks", 32'(acks), 32'd4);
    chk("held_wes", 32'(wes), 32'd4);
    ref_write(0, 14'h0050, 16'hC3C3, 2'b11);
    xfer(0, 1'b0, 14'h0050, 16'h0000, 2'b11);

    // WAIT=3: top word 0x1FFF, then back-to-back reads spaced 7 clocks.
    xfer(1, 1'b1, 14'h3FFE, 16'h9E37, 2'b11);
    xfer(1, 1'b0, 14'h3FFE, 16'h0000, 2'b11);
    @(negedge clk);
    wb_adr = 14'h3FFE; wb_we = 1'b0; wb_sel = 2'b11;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      chk("b2b_ack", 32'(ack[1]), 32'(((n - 1) % 7) == 5));
      if (ack[1]) chk("b2b_data", 32'(dat_o[1]), 32'h9E37);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    last_rd[1] = 16'h9E37;

    // Randomized traffic over a small preloaded word pool per instance.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 6; k++) begin
        pool[k] = 14'($urandom);
        xfer(i, 1'b1, pool[k], 16'($urandom), 2'b11);
      end
      for (int t = 0; t < 30; t++) begin
        idx = int'($urandom_range(0, 5));
        xfer(i, 1'($urandom), pool[idx], 16'($urandom), 2'($urandom));
      end
    end

    // Reset mid-idle with random bus inputs.
    @(negedge clk);
    wb_adr = 14'($urandom); wb_dat = 16'($urandom); wb_we = 1'($urandom);
    wb_sel = 2'($urandom); cyc = 2'($urandom); stb = 2'($urandom);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_ack", 32'(ack[i]), 32'd0);
      chk("mid_rst_dat", 32'(dat_o[i]), 32'd0);
      chk("mid_rst_addr", 32'(mem_addr[i]), 32'd0);
      chk("mid_rst_din", 32'(mem_din[i]), 32'd0);
      chk("mid_rst_we", 32'(mem_we[i]), 32'd0);
      chk("mid_rst_be", 32'(mem_be[i]), 32'd0);
    end
    @(negedge clk);
    cyc = '0; stb = '0;
    @(negedge clk);
    rst_n = 1'b1;
    wes = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (mem_we != 2'b00) wes++;
    end
    chk("post_rst_we", 32'(wes), 32'd0);
    last_rd[0] = '0; last_rd[1] = '0;
    xfer(0, 1'b0, 14'h0010, 16'h0000, 2'b11);
    xfer(1, 1'b0, 14'h3FFE, 16'h0000, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
